// File: rtl/tlp_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tlp_tx_arbiter
//  Function : Packet-atomic round-robin merge of NUM_SRC TLP TX streams into
//             one 64-bit stream toward the PCIe core. Arbitration latency is
//             one cycle, and one idle cycle separates consecutive packets.
//  Options  : `define PCILEECH_TXARB_PRIO0_EN gives source 0 strict priority.
//             The remaining sources stay round-robin among themselves.
//  Revision : 1.0  initial release
// ============================================================================
module tlp_tx_arbiter #(
   parameter int NUM_SRC = 3,
   parameter int CNT_W   = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_SRC*64-1:0]   src_data,
   input  logic [NUM_SRC*8-1:0]    src_keep,
   input  logic [NUM_SRC-1:0]      src_last,
   input  logic [NUM_SRC*22-1:0]   src_user,
   input  logic [NUM_SRC-1:0]      src_valid,
   output logic [NUM_SRC-1:0]      src_ready,
   output logic [63:0]             tx_data,
   output logic [7:0]              tx_keep,
   output logic                    tx_last,
   output logic [21:0]             tx_user,
   output logic                    tx_valid,
   input  logic                    tx_ready,
   output logic                    busy,
   output logic [NUM_SRC-1:0]      gnt,
   output logic [CNT_W-1:0]        pkt_count
);

   localparam int IW = $clog2(NUM_SRC);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t              state_q;
   logic [NUM_SRC-1:0]  gnt_q;
   logic [IW-1:0]       gidx_q;
   logic [IW-1:0]       last_gnt_q;
   logic                busy_q;
   logic [CNT_W-1:0]    pkt_count_q;

   logic                hi_vld_d;
   logic [IW-1:0]       hi_idx_d;
   logic                lo_vld_d;
   logic [IW-1:0]       lo_idx_d;
   logic                win_vld_d;
   logic [IW-1:0]       win_idx_d;
   logic                xfer_last_d;

   // Round-robin search: lowest valid index above last_gnt, else lowest
   // valid index at or below it (this realises the upward search with wrap).
   always_comb begin
      hi_vld_d = 1'b0;
      hi_idx_d = '0;
      lo_vld_d = 1'b0;
      lo_idx_d = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
`ifdef PCILEECH_TXARB_PRIO0_EN
         if (src_valid[i] && (i != 0)) begin
`else
         if (src_valid[i]) begin
`endif
            if (IW'(i) > last_gnt_q) begin
               hi_vld_d = 1'b1;
               hi_idx_d = IW'(i);
            end else begin
               lo_vld_d = 1'b1;
               lo_idx_d = IW'(i);
            end
         end
      end
      win_vld_d = hi_vld_d | lo_vld_d;
      win_idx_d = hi_vld_d ? hi_idx_d : lo_idx_d;
`ifdef PCILEECH_TXARB_PRIO0_EN
      // Source 0 pre-empts the round-robin choice whenever it requests.
      if (src_valid[0]) begin
         win_vld_d = 1'b1;
         win_idx_d = '0;
      end
`endif
   end

   // Output mux: the granted source drives tx_* and sees tx_ready; others stall.
   always_comb begin
      tx_data   = '0;
      tx_keep   = '0;
      tx_last   = 1'b0;
      tx_user   = '0;
      tx_valid  = 1'b0;
      src_ready = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if ((state_q == BUSY) && gnt_q[i]) begin
            tx_data      = src_data[i*64 +: 64];
            tx_keep      = src_keep[i*8 +: 8];
            tx_last      = src_last[i];
            tx_user      = src_user[i*22 +: 22];
            tx_valid     = src_valid[i];
            src_ready[i] = tx_ready;
         end
      end
      xfer_last_d = tx_valid & tx_ready & tx_last;
   end

   // Grant FSM: grant in IDLE, hold through the packet, release on last beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         gnt_q       <= '0;
         gidx_q      <= '0;
         busy_q      <= 1'b0;
         last_gnt_q  <= IW'(NUM_SRC - 1);
         pkt_count_q <= '0;
      end else if (state_q == IDLE) begin
         if (win_vld_d) begin
            state_q <= BUSY;
            gnt_q   <= {{(NUM_SRC-1){1'b0}}, 1'b1} << win_idx_d;
            gidx_q  <= win_idx_d;
            busy_q  <= 1'b1;
         end
      end else begin
         if (xfer_last_d) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            busy_q      <= 1'b0;
            pkt_count_q <= pkt_count_q + CNT_W'(1);
`ifdef PCILEECH_TXARB_PRIO0_EN
            // Priority grants to source 0 must not disturb the rotation.
            if (gidx_q != '0) begin
               last_gnt_q <= gidx_q;
            end
`else
            last_gnt_q  <= gidx_q;
`endif
         end
      end
   end

   assign gnt       = gnt_q;
   assign busy      = busy_q;
   assign pkt_count = pkt_count_q;

endmodule
`default_nettype wire
